// File: rtl/mvm_host_pkg.sv
// Shared types and default sizing for the matrix-vector accelerator host driver.
package mvm_host_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_COLLECT = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int T_DEF  = 16;
  localparam int N_DEF  = 4;
  localparam int M_DEF  = 8;
  localparam int CW_DEF = 32;

  localparam logic [CW_DEF-1:0] CYCLES_MAX = {CW_DEF{1'b1}};

endpackage

// File: rtl/mvm_result_ram.sv
// Result buffer: M x T simple dual-port RAM, one write port, one registered read port.
module mvm_result_ram
  import mvm_host_pkg::*;
#(
  parameter int T  = T_DEF,
  parameter int M  = M_DEF,
  parameter int AW = (M > 1) ? $clog2(M) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [T-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [T-1:0]  rdata_o
);

  logic [T-1:0] mem_q [M];
  logic [T-1:0] rdata_q;

  // NOTE: the storage array has no reset so it maps onto plain RAM; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // A same-cycle write to raddr_i is not forwarded: the old word is returned.
  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mvm_stream_host.sv
// Host-side driver: streams the x vector into the accelerator, collects M results, flags completion.
module mvm_stream_host
  import mvm_host_pkg::*;
#(
  parameter int T  = T_DEF,
  parameter int N  = N_DEF,
  parameter int M  = M_DEF,
  parameter int CW = CW_DEF,
  parameter int NW = (N > 1) ? $clog2(N) : 1,
  parameter int MW = (M > 1) ? $clog2(M) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          host_wr_en,
  input  logic [NW-1:0] host_wr_addr,
  input  logic [T-1:0]  host_wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic [MW-1:0] rd_addr,
  output logic [T-1:0]  rd_data,
  output logic [CW-1:0] cycles,
  output logic          acc_input_valid,
  input  logic          acc_input_ready,
  output logic [T-1:0]  acc_input_data,
  input  logic          acc_output_valid,
  output logic          acc_output_ready,
  input  logic [T-1:0]  acc_output_data
);

  localparam logic [CW-1:0] CNT_MAX = (CW <= CW_DEF) ? CW'(CYCLES_MAX) : {CW{1'b1}};

  state_e        state_q, state_d;
  logic [NW-1:0] tx_idx_q, tx_idx_d;
  logic [MW-1:0] rx_idx_q, rx_idx_d;
  logic [CW-1:0] cycles_q, cycles_d;
  logic          done_q, done_d;
  logic          res_we;
  logic [T-1:0]  x_q [N];

  // x survives runs and reset so the host can re-launch without rewriting it.
  always_ff @(posedge clk) begin
    if (host_wr_en && state_q == ST_IDLE) x_q[host_wr_addr] <= host_wr_data;
  end

  // NOTE: every variable is defaulted first so no path through the case leaves a latch.
  always_comb begin
    state_d          = state_q;
    tx_idx_d         = tx_idx_q;
    rx_idx_d         = rx_idx_q;
    cycles_d         = cycles_q;
    done_d           = done_q;
    acc_input_valid  = 1'b0;
    acc_output_ready = 1'b0;
    res_we           = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SEND;
          tx_idx_d = '0;
          rx_idx_d = '0;
          cycles_d = '0;
          done_d   = 1'b0;
        end
      end
      ST_SEND: begin
        acc_input_valid = 1'b1;
        if (acc_input_ready) begin
          tx_idx_d = tx_idx_q + NW'(1);
          if (tx_idx_q == NW'(N - 1)) state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        acc_output_ready = 1'b1;
        if (acc_output_valid) begin
          res_we   = 1'b1;
          rx_idx_d = rx_idx_q + MW'(1);
          if (rx_idx_q == MW'(M - 1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if ((state_q == ST_SEND || state_q == ST_COLLECT) && cycles_q != CNT_MAX)
      cycles_d = cycles_q + CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      tx_idx_q <= '0;
      rx_idx_q <= '0;
      cycles_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_idx_q <= tx_idx_d;
      rx_idx_q <= rx_idx_d;
      cycles_q <= cycles_d;
      done_q   <= done_d;
    end
  end

  assign busy           = (state_q == ST_SEND) || (state_q == ST_COLLECT);
  assign done           = done_q;
  assign cycles         = cycles_q;
  assign acc_input_data = (state_q == ST_SEND) ? x_q[tx_idx_q] : '0;

  mvm_result_ram #(
    .T (T),
    .M (M),
    .AW(MW)
  ) u_result_ram (
    .clk    (clk),
    .reset  (reset),
    .we_i   (res_we),
    .waddr_i(rx_idx_q),
    .wdata_i(acc_output_data),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

endmodule
